// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection scheduler: phase codes, lamp
// vectors and the timer width.
package traffic_pkg;

    localparam int TMR_W = 7;

    // Phase encodings (exposed on the phase output)
    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_G1   = 3'd1;
    localparam logic [2:0] PH_Y1   = 3'd2;
    localparam logic [2:0] PH_AR1  = 3'd3;
    localparam logic [2:0] PH_G2   = 3'd4;
    localparam logic [2:0] PH_Y2   = 3'd5;
    localparam logic [2:0] PH_AR2  = 3'd6;
    localparam logic [2:0] PH_PRE  = 3'd7;

    // Lamp vectors {green, yellow, left, red}
    localparam logic [3:0] LAMP_G = 4'b1000;
    localparam logic [3:0] LAMP_Y = 4'b0100;
    localparam logic [3:0] LAMP_L = 4'b0010;
    localparam logic [3:0] LAMP_R = 4'b0001;

endpackage

// File: rtl/intersection_scheduler_if.sv
// Control inputs and lamp/monitor outputs of the intersection scheduler.
interface intersection_scheduler_if;
    import traffic_pkg::*;

    logic             enable;
    logic             ped_req1;
    logic             ped_req2;
    logic             preempt;
    logic             preempt_dir;
    logic [3:0]       light1;
    logic [3:0]       light2;
    logic             walk1;
    logic             walk2;
    logic [2:0]       phase;
    logic [TMR_W-1:0] tmr;

    // Controller side: drives requests, observes lamps
    modport master (
        output enable, ped_req1, ped_req2, preempt, preempt_dir,
        input  light1, light2, walk1, walk2, phase, tmr
    );

    // Scheduler side
    modport slave (
        input  enable, ped_req1, ped_req2, preempt, preempt_dir,
        output light1, light2, walk1, walk2, phase, tmr
    );

endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// Load/decrement phase timer. Counts down to zero and holds there; also
// reports how many cycles of a green phase have elapsed.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned T_GMAX = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic [TMR_W-1:0] cnt_o,
    output logic             zero_o,
    output logic [TMR_W-1:0] spent_o
);

    localparam logic [TMR_W-1:0] GMAX_V = TMR_W'(T_GMAX);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement and saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign zero_o  = (cnt_q == '0);
    assign spent_o = GMAX_V - cnt_q;

endmodule

// File: rtl/intersection_scheduler.sv
// Two-direction intersection phase scheduler with pedestrian requests and
// emergency preemption. All outputs decode from registered state.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned T_GMIN = 10,
    parameter int unsigned T_GMAX = 40,
    parameter int unsigned T_YEL  = 5,
    parameter int unsigned T_AR   = 2,
    parameter int unsigned T_WALK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    intersection_scheduler_if.slave  bus
);

    localparam logic [TMR_W-1:0] G_LOAD  = TMR_W'(T_GMAX - 1);
    localparam logic [TMR_W-1:0] Y_LOAD  = TMR_W'(T_YEL - 1);
    localparam logic [TMR_W-1:0] AR_LOAD = TMR_W'(T_AR - 1);
    localparam logic [TMR_W-1:0] GMIN_V  = TMR_W'(T_GMIN);
    localparam logic [TMR_W-1:0] WALK_V  = TMR_W'(T_WALK);

    logic [2:0]       state_q, state_d;
    logic             pend1_q, pend1_d, pend2_q, pend2_d;
    logic             served1_q, served1_d, served2_q, served2_d;
    logic             pre_dir_q, pre_dir_d;
    logic             pre_seq_q, pre_seq_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic [TMR_W-1:0] tmr_cnt;
    logic [TMR_W-1:0] tmr_spent;
    logic             tmr_zero;

    logic             in_cycle;
    logic             eff_dir;
    logic             enter_g1, enter_g2;

    phase_timer #(
        .T_GMAX (T_GMAX)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero),
        .spent_o    (tmr_spent)
    );

    // A preemption sequence can only start from the running G/Y/AR cycle.
    // Its direction comes from the input on the first cycle, then from the
    // latched copy until PRE is left.
    assign in_cycle = (state_q != PH_IDLE) && (state_q != PH_PRE);
    assign eff_dir  = pre_seq_q ? pre_dir_q : bus.preempt_dir;

    // Next-phase selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_IDLE: if (bus.enable) state_d = PH_AR2;
            PH_G1: begin
                if (bus.preempt && !eff_dir)                   state_d = PH_PRE;
                else if (bus.preempt)                          state_d = PH_Y1;
                else if (tmr_zero)                             state_d = PH_Y1;
                else if (pend2_q && (tmr_spent >= GMIN_V))     state_d = PH_Y1;
            end
            PH_Y1: if (tmr_zero) state_d = PH_AR1;
            PH_AR1: begin
                if (tmr_zero) begin
                    if (bus.preempt)      state_d = PH_PRE;
                    else if (!bus.enable) state_d = PH_IDLE;
                    else                  state_d = PH_G2;
                end
            end
            PH_G2: begin
                if (bus.preempt && eff_dir)                    state_d = PH_PRE;
                else if (bus.preempt)                          state_d = PH_Y2;
                else if (tmr_zero)                             state_d = PH_Y2;
                else if (pend1_q && (tmr_spent >= GMIN_V))     state_d = PH_Y2;
            end
            PH_Y2: if (tmr_zero) state_d = PH_AR2;
            PH_AR2: begin
                if (tmr_zero) begin
                    if (bus.preempt)      state_d = PH_PRE;
                    else if (!bus.enable) state_d = PH_IDLE;
                    else                  state_d = PH_G1;
                end
            end
            PH_PRE: if (!bus.preempt) state_d = pre_dir_q ? PH_Y2 : PH_Y1;
            default: state_d = PH_IDLE;
        endcase
    end

    // Timer reload on every phase change; untimed phases park the timer at 0
    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        case (state_d)
            PH_G1, PH_G2:   tmr_load_val = G_LOAD;
            PH_Y1, PH_Y2:   tmr_load_val = Y_LOAD;
            PH_AR1, PH_AR2: tmr_load_val = AR_LOAD;
            default:        tmr_load_val = '0;
        endcase
    end

    // Pedestrian latches, walk arming and preemption direction tracking.
    // servedN remembers whether the green just entered answered a request,
    // so walk only lights for greens that actually serve pedestrians.
    always_comb begin
        enter_g1  = (state_d == PH_G1) && (state_q != PH_G1);
        enter_g2  = (state_d == PH_G2) && (state_q != PH_G2);
        pend1_d   = bus.ped_req1 | (pend1_q & ~enter_g1);
        pend2_d   = bus.ped_req2 | (pend2_q & ~enter_g2);
        served1_d = enter_g1 ? pend1_q : served1_q;
        served2_d = enter_g2 ? pend2_q : served2_q;
        pre_dir_d = (bus.preempt && !pre_seq_q && in_cycle) ? bus.preempt_dir : pre_dir_q;
        if (state_q == PH_PRE) begin
            pre_seq_d = (state_d == PH_PRE);
        end else begin
            pre_seq_d = bus.preempt && in_cycle;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PH_IDLE;
            pend1_q   <= 1'b0;
            pend2_q   <= 1'b0;
            served1_q <= 1'b0;
            served2_q <= 1'b0;
            pre_dir_q <= 1'b0;
            pre_seq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend1_q   <= pend1_d;
            pend2_q   <= pend2_d;
            served1_q <= served1_d;
            served2_q <= served2_d;
            pre_dir_q <= pre_dir_d;
            pre_seq_q <= pre_seq_d;
        end
    end

    // Moore lamp and walk decode
    always_comb begin
        bus.light1 = LAMP_R;
        bus.light2 = LAMP_R;
        case (state_q)
            PH_G1:  bus.light1 = LAMP_G;
            PH_Y1:  bus.light1 = LAMP_Y;
            PH_G2:  bus.light2 = LAMP_G;
            PH_Y2:  bus.light2 = LAMP_Y;
            PH_PRE: begin
                if (pre_dir_q) bus.light2 = LAMP_G;
                else           bus.light1 = LAMP_G;
            end
            default: begin
                bus.light1 = LAMP_R;
                bus.light2 = LAMP_R;
            end
        endcase
        bus.walk1 = (state_q == PH_G1) && served1_q && (tmr_spent <= WALK_V);
        bus.walk2 = (state_q == PH_G2) && served2_q && (tmr_spent <= WALK_V);
        bus.phase = state_q;
        bus.tmr   = tmr_cnt;
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed self-checking bench for intersection_scheduler (default timing).
// Cycle 0 is the first cycle after reset release; inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_intersection_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    intersection_scheduler_if bus ();

    intersection_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    // Reset for one edge, then release with enable=1 in cycle 0
    task automatic start();
        rst = 1'b1;
        bus.enable = 1'b0; bus.ped_req1 = 1'b0; bus.ped_req2 = 1'b0;
        bus.preempt = 1'b0; bus.preempt_dir = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        bus.enable = 1'b1;
    endtask

    // Hand-derived phase sequence after enable with no requests
    function automatic logic [2:0] base_phase(input int c);
        if (c == 0)  return 3'd0;
        if (c <= 2)  return 3'd6;
        if (c <= 42) return 3'd1;
        if (c <= 47) return 3'd2;
        if (c <= 49) return 3'd3;
        if (c <= 89) return 3'd4;
        if (c <= 94) return 3'd5;
        if (c <= 96) return 3'd6;
        return 3'd1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.enable = 1'b1; bus.ped_req1 = 1'b0; bus.ped_req2 = 1'b0;
        bus.preempt = 1'b0; bus.preempt_dir = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", bus.phase); end
        n_cmp++; if (bus.light1 !== 4'b0001) begin n_bad++; $display("FAIL reset_light1: got %b want 0001", bus.light1); end
        n_cmp++; if (bus.light2 !== 4'b0001) begin n_bad++; $display("FAIL reset_light2: got %b want 0001", bus.light2); end
        n_cmp++; if ({bus.walk1, bus.walk2} !== 2'b00) begin n_bad++; $display("FAIL reset_walk: got %b want 00", {bus.walk1, bus.walk2}); end
        n_cmp++; if (bus.tmr !== 7'd0) begin n_bad++; $display("FAIL reset_tmr: got %0d want 0", bus.tmr); end
    endtask

    task automatic test_cycle();
        start();
        for (int c = 0; c <= 97; c++) begin
            goto(c);
            n_cmp++;
            if (bus.phase !== base_phase(c)) begin
                n_bad++; $display("FAIL cycle_phase@%0d: got %0d want %0d", c, bus.phase, base_phase(c));
            end
            if (c == 1) begin
                n_cmp++; if (bus.tmr !== 7'd1) begin n_bad++; $display("FAIL cycle_tmr_ar: got %0d want 1", bus.tmr); end
            end
            if (c == 3) begin
                n_cmp++; if (bus.tmr !== 7'd39) begin n_bad++; $display("FAIL cycle_tmr_g: got %0d want 39", bus.tmr); end
                n_cmp++; if (bus.walk1 !== 1'b0) begin n_bad++; $display("FAIL cycle_nowalk: got %b want 0", bus.walk1); end
            end
            if (c == 42) begin
                n_cmp++; if (bus.tmr !== 7'd0) begin n_bad++; $display("FAIL cycle_tmr_gend: got %0d want 0", bus.tmr); end
            end
            if (c == 10) begin
                n_cmp++; if ({bus.light1, bus.light2} !== 8'b1000_0001) begin n_bad++; $display("FAIL cycle_lights_g1: got %b want 10000001", {bus.light1, bus.light2}); end
            end
            if (c == 45) begin
                n_cmp++; if ({bus.light1, bus.light2} !== 8'b0100_0001) begin n_bad++; $display("FAIL cycle_lights_y1: got %b want 01000001", {bus.light1, bus.light2}); end
                n_cmp++; if (bus.tmr !== 7'd2) begin n_bad++; $display("FAIL cycle_tmr_y: got %0d want 2", bus.tmr); end
            end
            if (c == 48) begin
                n_cmp++; if ({bus.light1, bus.light2} !== 8'b0001_0001) begin n_bad++; $display("FAIL cycle_lights_ar: got %b want 00010001", {bus.light1, bus.light2}); end
            end
        end
    endtask

    task automatic test_ped();
        start();
        goto(5);
        bus.ped_req2 = 1'b1;
        tick();
        bus.ped_req2 = 1'b0;
        goto(12); n_cmp++; if (bus.phase !== 3'd1) begin n_bad++; $display("FAIL ped_g1_last: got %0d want 1", bus.phase); end
        goto(13); n_cmp++; if (bus.phase !== 3'd2) begin n_bad++; $display("FAIL ped_y1_start: got %0d want 2", bus.phase); end
        goto(17); n_cmp++; if (bus.phase !== 3'd2) begin n_bad++; $display("FAIL ped_y1_end: got %0d want 2", bus.phase); end
        goto(18); n_cmp++; if (bus.phase !== 3'd3) begin n_bad++; $display("FAIL ped_ar1: got %0d want 3", bus.phase); end
        goto(19); n_cmp++; if (bus.walk2 !== 1'b0) begin n_bad++; $display("FAIL ped_walk_pre: got %b want 0", bus.walk2); end
        goto(20); n_cmp++; if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL ped_g2: got %0d want 4", bus.phase); end
        for (int c = 20; c <= 28; c++) begin
            goto(c);
            n_cmp++;
            if (bus.walk2 !== (c <= 27)) begin n_bad++; $display("FAIL ped_walk2@%0d: got %b want %b", c, bus.walk2, (c <= 27)); end
        end
        // Request was served on G2 entry: G2 now runs its full length
        goto(59); n_cmp++; if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL ped_cleared: got %0d want 4", bus.phase); end
        n_cmp++; if (bus.walk1 !== 1'b0) begin n_bad++; $display("FAIL ped_walk1: got %b want 0", bus.walk1); end
    endtask

    task automatic test_preempt_opp();
        start();
        goto(20);
        bus.preempt = 1'b1; bus.preempt_dir = 1'b1;
        tick();
        n_cmp++; if (bus.phase !== 3'd2) begin n_bad++; $display("FAIL popp_y1: got %0d want 2", bus.phase); end
        goto(25); n_cmp++; if (bus.phase !== 3'd2) begin n_bad++; $display("FAIL popp_y1_end: got %0d want 2", bus.phase); end
        goto(26); n_cmp++; if (bus.phase !== 3'd3) begin n_bad++; $display("FAIL popp_ar1: got %0d want 3", bus.phase); end
        goto(28); n_cmp++; if (bus.phase !== 3'd7) begin n_bad++; $display("FAIL popp_pre: got %0d want 7", bus.phase); end
        n_cmp++; if ({bus.light1, bus.light2} !== 8'b0001_1000) begin n_bad++; $display("FAIL popp_lights: got %b want 00011000", {bus.light1, bus.light2}); end
        n_cmp++; if (bus.tmr !== 7'd0) begin n_bad++; $display("FAIL popp_tmr: got %0d want 0", bus.tmr); end
        // Direction is latched: changing the input mid-PRE must not matter
        goto(40); bus.preempt_dir = 1'b0;
        goto(45); n_cmp++; if ({bus.light1, bus.light2} !== 8'b0001_1000) begin n_bad++; $display("FAIL popp_latched: got %b want 00011000", {bus.light1, bus.light2}); end
        goto(60); bus.preempt = 1'b0;
        goto(61); n_cmp++; if (bus.phase !== 3'd5) begin n_bad++; $display("FAIL popp_y2: got %0d want 5", bus.phase); end
        goto(66); n_cmp++; if (bus.phase !== 3'd6) begin n_bad++; $display("FAIL popp_ar2: got %0d want 6", bus.phase); end
        goto(68); n_cmp++; if (bus.phase !== 3'd1) begin n_bad++; $display("FAIL popp_g1: got %0d want 1", bus.phase); end
    endtask

    task automatic test_preempt_same();
        start();
        goto(10);
        n_cmp++; if (bus.light1 !== 4'b1000) begin n_bad++; $display("FAIL psame_g1: got %b want 1000", bus.light1); end
        bus.preempt = 1'b1; bus.preempt_dir = 1'b0;
        tick();
        n_cmp++; if (bus.phase !== 3'd7) begin n_bad++; $display("FAIL psame_pre: got %0d want 7", bus.phase); end
        n_cmp++; if ({bus.light1, bus.light2} !== 8'b1000_0001) begin n_bad++; $display("FAIL psame_lights: got %b want 10000001", {bus.light1, bus.light2}); end
        goto(15); bus.ped_req1 = 1'b1;
        tick(); bus.ped_req1 = 1'b0;
        n_cmp++; if (bus.walk1 !== 1'b0) begin n_bad++; $display("FAIL psame_nowalk: got %b want 0", bus.walk1); end
        goto(20); bus.preempt = 1'b0;
        goto(21); n_cmp++; if (bus.phase !== 3'd2) begin n_bad++; $display("FAIL psame_y1: got %0d want 2", bus.phase); end
        goto(28); n_cmp++; if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL psame_g2: got %0d want 4", bus.phase); end
        // pend1 still set, so G2 is cut to its minimum
        goto(37); n_cmp++; if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL psame_g2_last: got %0d want 4", bus.phase); end
        goto(38); n_cmp++; if (bus.phase !== 3'd5) begin n_bad++; $display("FAIL psame_y2: got %0d want 5", bus.phase); end
        goto(45); n_cmp++; if (bus.phase !== 3'd1) begin n_bad++; $display("FAIL psame_g1b: got %0d want 1", bus.phase); end
        n_cmp++; if (bus.walk1 !== 1'b1) begin n_bad++; $display("FAIL psame_walk_first: got %b want 1", bus.walk1); end
        goto(52); n_cmp++; if (bus.walk1 !== 1'b1) begin n_bad++; $display("FAIL psame_walk_last: got %b want 1", bus.walk1); end
        goto(53); n_cmp++; if (bus.walk1 !== 1'b0) begin n_bad++; $display("FAIL psame_walk_off: got %b want 0", bus.walk1); end
    endtask

    task automatic test_disable();
        start();
        goto(55); bus.enable = 1'b0;
        goto(89); n_cmp++; if (bus.phase !== 3'd4) begin n_bad++; $display("FAIL dis_g2_full: got %0d want 4", bus.phase); end
        goto(90); n_cmp++; if (bus.phase !== 3'd5) begin n_bad++; $display("FAIL dis_y2: got %0d want 5", bus.phase); end
        goto(96); n_cmp++; if (bus.phase !== 3'd6) begin n_bad++; $display("FAIL dis_ar2: got %0d want 6", bus.phase); end
        goto(97); n_cmp++; if (bus.phase !== 3'd0) begin n_bad++; $display("FAIL dis_idle: got %0d want 0", bus.phase); end
        goto(105); n_cmp++; if (bus.phase !== 3'd0) begin n_bad++; $display("FAIL dis_idle_hold: got %0d want 0", bus.phase); end
        n_cmp++; if ({bus.light1, bus.light2} !== 8'b0001_0001) begin n_bad++; $display("FAIL dis_lights: got %b want 00010001", {bus.light1, bus.light2}); end
    endtask

    task automatic test_reset_in_pre();
        start();
        goto(10); bus.preempt = 1'b1; bus.preempt_dir = 1'b1;
        goto(15); n_cmp++; if (bus.phase !== 3'd2) begin n_bad++; $display("FAIL rpre_y1: got %0d want 2", bus.phase); end
        goto(18); n_cmp++; if (bus.phase !== 3'd7) begin n_bad++; $display("FAIL rpre_pre: got %0d want 7", bus.phase); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.phase !== 3'd0) begin n_bad++; $display("FAIL rpre_phase: got %0d want 0", bus.phase); end
        n_cmp++; if ({bus.light1, bus.light2} !== 8'b0001_0001) begin n_bad++; $display("FAIL rpre_lights: got %b want 00010001", {bus.light1, bus.light2}); end
        n_cmp++; if ({bus.walk1, bus.walk2, bus.tmr} !== 9'd0) begin n_bad++; $display("FAIL rpre_walk_tmr: got %b want 0", {bus.walk1, bus.walk2, bus.tmr}); end
        bus.preempt = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0; bus.ped_req1 = 1'b0; bus.ped_req2 = 1'b0;
        bus.preempt = 1'b0; bus.preempt_dir = 1'b0;
        test_reset();
        test_cycle();
        test_ped();
        test_preempt_opp();
        test_preempt_same();
        test_disable();
        test_reset_in_pre();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
